// File: rtl/fc_layer_sequencer.sv
// Fully connected layer sequencer: steps neuron groups through clear/feed/drain/capture over a shared MAC lane bank and streams one result per neuron; ReLU on output when FC_SEQ_RELU_EN is defined.
// Latency N_IN+3 cycles per group to first result; out_valid/out_ready stall freezes out_data/out_idx with no buffer reads or lane strobes.
module fc_layer_sequencer #(
  parameter int N_IN  = 64,
  parameter int N_OUT = 10,
  parameter int LANES = 5,
  parameter int AW    = $clog2(N_IN),
  parameter int WW    = $clog2(N_IN * ((N_OUT + LANES - 1) / LANES)),
  parameter int IW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    act_rd,
  output logic [AW-1:0]           act_addr,
  output logic [WW-1:0]           wgt_addr,
  output logic                    lane_clr,
  output logic                    lane_en,
  input  logic [LANES*16-1:0]     lane_acc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [15:0]      out_data,
  output logic [IW-1:0]           out_idx
);

  localparam int NG = (N_OUT + LANES - 1) / LANES;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int JW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [AW-1:0] K_LAST   = AW'(N_IN - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_OUT - 1);
  localparam logic [JW-1:0] J_LAST   = JW'(LANES - 1);
  localparam logic [GW-1:0] G_LAST   = GW'(NG - 1);
  localparam logic [WW-1:0] W_STEP   = WW'(N_IN);

  typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, CAPT, EMIT} state_t;

  state_t             state;
  logic [GW-1:0]      g;
  logic [JW-1:0]      j;
  logic [WW-1:0]      wbase;
  logic signed [15:0] shadow [LANES];

  logic               grp_end;
  logic               last_grp;
  logic [JW-1:0]      j_nxt;

  function automatic logic signed [15:0] relu(input logic signed [15:0] x);
`ifdef FC_SEQ_RELU_EN
    relu = x[15] ? 16'sd0 : x;
`else
    relu = x;
`endif
  endfunction

  // A group ends on its last lane, or earlier on the final neuron of a short last group.
  assign grp_end  = (j == J_LAST) || (out_idx == IDX_LAST);
  assign last_grp = (g == G_LAST);
  assign j_nxt    = j + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      g         <= '0;
      j         <= '0;
      wbase     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      act_rd    <= 1'b0;
      act_addr  <= '0;
      wgt_addr  <= '0;
      lane_clr  <= 1'b0;
      lane_en   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      for (int i = 0; i < LANES; i++) shadow[i] <= '0;
    end else begin
      done     <= 1'b0;
      lane_clr <= 1'b0;
      // Buffers answer one cycle after the read strobe.
      lane_en  <= act_rd;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CLR;
            lane_clr <= 1'b1;
            busy     <= 1'b1;
            g        <= '0;
            wbase    <= '0;
            out_idx  <= '0;
          end
        end
        CLR: begin
          state    <= FEED;
          act_rd   <= 1'b1;
          act_addr <= '0;
          wgt_addr <= wbase;
        end
        FEED: begin
          if (act_addr == K_LAST) begin
            state  <= DRAIN;
            act_rd <= 1'b0;
          end else begin
            act_addr <= act_addr + 1'b1;
            wgt_addr <= wgt_addr + 1'b1;
          end
        end
        DRAIN: state <= CAPT;
        CAPT: begin
          for (int i = 0; i < LANES; i++) shadow[i] <= lane_acc[16*i +: 16];
          j         <= '0;
          out_valid <= 1'b1;
          out_data  <= relu(lane_acc[15:0]);
          state     <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            if (grp_end) begin
              out_valid <= 1'b0;
              if (last_grp) begin
                state <= IDLE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state    <= CLR;
                lane_clr <= 1'b1;
                g        <= g + 1'b1;
                wbase    <= wbase + W_STEP;
                out_idx  <= out_idx + 1'b1;
              end
            end else begin
              j        <= j_nxt;
              out_idx  <= out_idx + 1'b1;
              out_data <= relu(shadow[j_nxt]);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer with N_IN=4, N_OUT=3, LANES=2 and a behavioural acc += act*w lane bank.
module tb_fc_layer_sequencer;

  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int LANES = 2;
  localparam int AW    = 2;
  localparam int WW    = 3;
  localparam int IW    = 2;

`ifdef FC_SEQ_RELU_EN
  localparam logic [15:0] EXP2 = 16'h0000;
`else
  localparam logic [15:0] EXP2 = 16'hFFF6;
`endif

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 act_rd;
  logic [AW-1:0]        act_addr;
  logic [WW-1:0]        wgt_addr;
  logic                 lane_clr;
  logic                 lane_en;
  logic [LANES*16-1:0]  lane_acc;
  logic                 out_valid;
  logic                 out_ready;
  logic [15:0]          out_data;
  logic [IW-1:0]        out_idx;

  fc_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .act_rd(act_rd), .act_addr(act_addr), .wgt_addr(wgt_addr),
    .lane_clr(lane_clr), .lane_en(lane_en), .lane_acc(lane_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane bank model: acts are index+1, weights +1 except neuron 2 at -1.
  logic signed [15:0] acc0 = '0;
  logic signed [15:0] acc1 = '0;
  logic [2:0]         b_act = '0;
  logic               b_grp = 1'b0;

  function automatic int wt(input logic grp, input int lane);
    return ((int'(grp) * 2 + lane) == 2) ? -1 : 1;
  endfunction

  always @(posedge clk) begin
    if (act_rd) begin
      b_act <= 3'(act_addr) + 3'd1;
      b_grp <= (wgt_addr >= 3'd4);
    end
    acc0 <= lane_clr ? 16'sd0 : (lane_en ? acc0 + 16'(wt(b_grp, 0) * int'(b_act)) : acc0);
    acc1 <= lane_clr ? 16'sd0 : (lane_en ? acc1 + 16'(wt(b_grp, 1) * int'(b_act)) : acc1);
  end
  assign lane_acc = {acc1, acc0};

  int errors = 0;
  int checks = 0;

  logic [IW-1:0] res_idx [$];
  logic [15:0]   res_dat [$];
  logic [AW-1:0] aq [$];
  logic [WW-1:0] wq [$];
  int            en_cnt [2];
  int            done_c;
  int            stall_cnt;
  int            stall_bad;
  int            busy_bad;
  logic [15:0]   exp_dat [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check(tag, 32'({busy, done, act_rd, act_addr, wgt_addr, lane_clr, lane_en,
                    out_valid, out_data, out_idx}), 32'd0);
  endtask

  // Entered on the CLR-cycle negedge; returns on the done-cycle negedge.
  task automatic run_layer(input int bp, input bit midstart, input bit relaunch);
    int grp;
    logic [15:0]   snap_d;
    logic [IW-1:0] snap_i;
    res_idx.delete(); res_dat.delete(); aq.delete(); wq.delete();
    en_cnt[0] = 0; en_cnt[1] = 0;
    done_c = -1; stall_cnt = 0; stall_bad = 0; busy_bad = 0; grp = 0;
    snap_d = '0; snap_i = '0;
    for (int c = 0; c < 80; c++) begin
      start = midstart && (c == 3);
      if (lane_clr && c > 0) grp++;
      if (lane_en && grp < 2) en_cnt[grp]++;
      if (act_rd) begin
        aq.push_back(act_addr);
        wq.push_back(wgt_addr);
      end
      if (done) begin
        done_c = c;
        if (busy) busy_bad++;
        start = relaunch;
        break;
      end
      if (!busy) busy_bad++;
      if (out_valid && out_idx == 2'd1 && stall_cnt < bp) begin
        if (stall_cnt == 0) begin
          snap_d = out_data;
          snap_i = out_idx;
        end else if (out_data !== snap_d || out_idx !== snap_i) begin
          stall_bad++;
        end
        if (act_rd || lane_en || lane_clr) stall_bad++;
        stall_cnt++;
        out_ready = 1'b0;
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          res_idx.push_back(out_idx);
          res_dat.push_back(out_data);
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("layer_done_seen", 32'(done_c >= 0), 32'd1);
  endtask

  task automatic check_results(input string tag);
    check({tag, "_count"}, 32'(res_idx.size()), 32'd3);
    for (int i = 0; i < 3 && i < res_idx.size(); i++) begin
      check($sformatf("%s_idx%0d", tag, i), 32'(res_idx[i]), 32'(i));
      check($sformatf("%s_dat%0d", tag, i), 32'(res_dat[i]), 32'(exp_dat[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int dn;
    exp_dat[0] = 16'd10;
    exp_dat[1] = 16'd10;
    exp_dat[2] = EXP2;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic pass with address, strobe and latency checks
    start = 1'b1;
    @(negedge clk);
    check("clr_cycle", 32'({busy, lane_clr, act_rd, out_valid}), 32'b1100);
    run_layer(0, 1'b0, 1'b0);
    check("basic_latency", 32'(done_c), 32'd17);
    check("basic_busy_window", 32'(busy_bad), 32'd0);
    check_results("basic");
    check("feed_reads", 32'(aq.size()), 32'd8);
    for (int i = 0; i < 8 && i < aq.size(); i++) begin
      check($sformatf("act_addr%0d", i), 32'(aq[i]), 32'(i % 4));
      check($sformatf("wgt_addr%0d", i), 32'(wq[i]), 32'(i));
    end
    check("lane_en_g0", 32'(en_cnt[0]), 32'd4);
    check("lane_en_g1", 32'(en_cnt[1]), 32'd4);
    @(negedge clk);
    check("done_pulse_end", 32'({done, busy}), 32'd0);

    // Backpressure at idx 1 for 5 cycles
    start = 1'b1;
    @(negedge clk);
    run_layer(5, 1'b0, 1'b0);
    check("bp_stall_cycles", 32'(stall_cnt), 32'd5);
    check("bp_stall_stable", 32'(stall_bad), 32'd0);
    check("bp_latency", 32'(done_c), 32'd22);
    check_results("bp");
    @(negedge clk);

    // Start mid-FEED is ignored; start with done relaunches
    start = 1'b1;
    @(negedge clk);
    run_layer(0, 1'b1, 1'b1);
    check("midstart_latency", 32'(done_c), 32'd17);
    check("midstart_busy_window", 32'(busy_bad), 32'd0);
    check_results("midstart");
    @(negedge clk);
    check("relaunch_clr", 32'({busy, lane_clr, done}), 32'b110);
    run_layer(0, 1'b0, 1'b0);
    check("relaunch_latency", 32'(done_c), 32'd17);
    check_results("relaunch");
    @(negedge clk);

    // Reset while idx 0 is presented
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 30 && !out_valid; c++) @(negedge clk);
    out_ready = 1'b0;
    check("rst_valid_seen", 32'(out_valid), 32'd1);
    check("rst_at_idx0", 32'(out_idx), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset_clear");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy || out_valid) dn++;
    end
    check("no_done_after_reset", 32'(dn), 32'd0);
    start = 1'b1;
    @(negedge clk);
    run_layer(0, 1'b0, 1'b0);
    check("post_reset_latency", 32'(done_c), 32'd17);
    check_results("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fc_layer_sequencer.md
# fc_layer_sequencer

Sequencer for one fully connected layer computed on a shared bank of `LANES` digital in-memory MAC lanes. It sits between the activation/weight buffers and the lane bank. The block steps neuron groups through clear, feed and drain phases. It then captures the lane accumulators, applies ReLU (compile option) and streams one 16-bit result per neuron over a valid/ready handshake. A layer of `N_OUT` neurons takes `ceil(N_OUT/LANES)` group passes.

## Interface
- `N_IN`, 64: inputs per neuron (≥2)
- `N_OUT`, 10: neurons in the layer (≥1)
- `LANES`, 5: parallel MAC lanes (≥1)
- `AW`, `$clog2(N_IN)`: activation address width
- `WW`, `$clog2(N_IN*ceil(N_OUT/LANES))`: weight-row address width
- `clk`, in, 1: clock, rising edge
- `rst_n`, in, 1: asynchronous active-low reset
- `start`, in, 1: launch a layer; sampled only in IDLE
- `busy`, out, 1: high from the cycle after `start` is accepted until the layer completes
- `done`, out, 1: one-cycle pulse at completion
- `act_rd`, out, 1: activation/weight buffer read strobe
- `act_addr`, out, AW: activation index
- `wgt_addr`, out, WW: weight row = group*N_IN + index; each row holds LANES weights
- `lane_clr`, out, 1: zero all lane accumulators
- `lane_en`, out, 1: lanes accumulate buffer data this cycle
- `lane_acc`, in, LANES*16, signed: lane accumulators; lane i at bits [16i+15:16i]
- `out_valid`, out, 1: result available
- `out_ready`, in, 1: sink accepts the result
- `out_data`, out, 16, signed: neuron result
- `out_idx`, out, `$clog2(N_OUT)`: neuron index of `out_data`

## Operation
- All outputs are registered. Reset value of every output is 0, and the state is IDLE.
- FSM states:
  - IDLE: `start` → CLR with group g=0.
  - CLR: `lane_clr`=1 for one cycle → FEED with k=0.
  - FEED: `act_rd`=1, `act_addr`=k, `wgt_addr`=g*N_IN+k, for k=0..N_IN-1. After k=N_IN-1 → DRAIN.
  - DRAIN: one cycle with `act_rd`=0 → CAPT.
  - CAPT: latch `lane_acc` into a shadow register at the cycle end; lane counter j=0 → EMIT.
  - EMIT: present lane j. On `out_valid && out_ready`, j advances. The group ends when j=LANES-1 or g*LANES+j=N_OUT-1. At group end: → CLR with g+1, or → IDLE with `done`=1 if this was the last group.
- Buffers have 1-cycle read latency. `lane_en` is `act_rd` delayed one cycle, so it is high for the FEED cycles k≥1 plus the DRAIN cycle: exactly N_IN cycles.
- `out_data` = shadow[j], passed through ReLU when enabled. `out_idx` = g*LANES+j.
- In the last group, lanes with index ≥ N_OUT are never emitted.
- `start` outside IDLE is ignored. `start` held high re-launches only after returning to IDLE.
- The block performs no arithmetic besides ReLU. Width is 16 bits throughout, and the sign is taken from bit 15.

## Timing
- `busy` rises in the CLR cycle and falls in the cycle `done` pulses. `start` in that same cycle is accepted.
- Per group, from CLR to the first `out_valid`: 1 (CLR) + N_IN (FEED) + 1 (DRAIN) + 1 (CAPT) = N_IN+3 cycles.
- EMIT takes at least one cycle per result, with back-to-back results when `out_ready` is held high.
- Layer latency with `out_ready`=1 is ceil(N_OUT/LANES)*(N_IN+3) + N_OUT cycles from the CLR entry to `done`.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_idx` hold stable, and no buffer reads or lane strobes occur.
- `out_valid` drops in the cycle after the final handshake of a group. It stays low through CLR..CAPT.
- Asserting `rst_n` low at any point returns the FSM to IDLE immediately and clears every output. In-flight results are discarded and no `done` is issued.

## Configuration
- `FC_SEQ_RELU_EN` defined: `out_data` = 0 when shadow[j][15]=1, else shadow[j].
- `FC_SEQ_RELU_EN` undefined: `out_data` = shadow[j] unmodified, including negative values.

## Test plan
- **Basic pass, ReLU on.** Parameters N_IN=4, N_OUT=3, LANES=2. Lane model is acc += act*w, with acts 1,2,3,4 and all weights +1 except neuron 2 at −1. Expected: outputs (idx, data) = (0, 10), (1, 10), (2, 0). `done` occurs 2*(4+3)+3=17 cycles after CLR entry.
- **Same stimulus, ReLU off.** Neuron 2 gives `out_data`=16'hFFF6 (−10).
- **Backpressure.** Hold `out_ready`=0 for 5 cycles at idx 1. `out_data` and `out_idx` hold stable, `act_rd` stays 0, and the sequence completes unchanged afterward.
- **Address sequence.** Group 1 FEED issues `wgt_addr`=4,5,6,7 and `act_addr`=0..3. `lane_en` is high for exactly 4 cycles per group.
- **Start while busy, then a re-launch.** A `start` pulse mid-FEED is ignored. A `start` coincident with `done` launches a second layer with identical results.
- **Reset mid-operation.** Pull `rst_n` low during EMIT of idx 0. All outputs go to 0 asynchronously, and no `done` is issued. A following `start` produces the full result sequence.
